sparse_dot_engine: RTL and testbench

- Parametrised index-matching multiply-accumulate engine; the next-generation replacement for the single index-compare element in the sparse matrix coprocessor.
- Consumes two streams of (index, value) pairs, each sorted ascending: row A and column B.
- Intersects the streams on index and accumulates the products of matched values. Supports a dot-product mode and a match-count mode.
- Sits between the comm receive path (operand streams) and the result/transmit path.

---
 rtl/sparse_pkg.sv | 25 ++
 rtl/sparse_mac.sv | 87 ++++++++
 rtl/sparse_dot_engine.sv | 177 +++++++++++++++++
 tb/tb_sparse_dot_engine.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared types and default widths for the sparse index-matching MAC engine.
//   state_t : engine control states
//   mode_t  : accumulation mode (dot product or match count)
//   DEF_*   : default index / value / accumulator widths
package sparse_pkg;

    localparam int DEF_IDX_W  = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN_A,
        DRAIN_B,
        FLUSH,
        DONE
    } state_t;

    typedef enum logic {
        MODE_DOT   = 1'b0,
        MODE_COUNT = 1'b1
    } mode_t;

endpackage

// File: rtl/sparse_mac.sv
// Product register followed by a saturating accumulator.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator, pending product and overflow flag
//   en         : issue a product this cycle (a_val*b_val, or +1 in count mode)
//   mode       : MODE_DOT / MODE_COUNT
//   a_val,b_val: signed operands
//   acc        : accumulated value (signed, saturating)
//   overflow   : sticky, set whenever an accumulation clamps
module sparse_mac
    import sparse_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  mode_t             mode,
    input  logic [DATA_W-1:0] a_val,
    input  logic [DATA_W-1:0] b_val,
    output logic [ACC_W-1:0]  acc,
    output logic              overflow
);

    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_v;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic        [ACC_W:0]    sum;
    logic                     clamp_hi;
    logic                     clamp_lo;

    always_comb begin
        if (mode == MODE_COUNT) begin
            prod_d = PROD_W'(1);
        end else begin
            prod_d = $signed(a_val) * $signed(b_val);
        end
    end

    // One guard bit: the top two sum bits disagree exactly when the
    // true sum is outside the ACC_W-bit signed range.
    always_comb begin
        prod_ext = ACC_W'(prod_q);
        sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        clamp_hi = ~sum[ACC_W] &  sum[ACC_W-1];
        clamp_lo =  sum[ACC_W] & ~sum[ACC_W-1];
        if (clamp_hi) begin
            acc_d = ACC_MAX;
        end else if (clamp_lo) begin
            acc_d = ACC_MIN;
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prod_q   <= '0;
            prod_v   <= 1'b0;
            acc_q    <= '0;
            overflow <= 1'b0;
        end else begin
            prod_v <= en;
            if (en) begin
                prod_q <= prod_d;
            end
            if (prod_v) begin
                acc_q <= acc_d;
                if (clamp_hi || clamp_lo) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sparse_dot_engine.sv
// Index-matching multiply-accumulate engine. Intersects two ascending
// (index, value) streams and accumulates matched products or match counts.
//   clk, reset           : clock, synchronous active-high reset
//   start, mode          : job start (IDLE only), mode latched on start
//   a_* / b_*            : valid/ready operand streams with index, value, last
//   busy                 : high outside IDLE
//   res_valid/res_ready  : result handshake
//   result, overflow     : accumulated result and sticky saturation flag
//   order_err            : sticky flag for a non-increasing index in either stream
module sparse_dot_engine
    import sparse_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [DATA_W-1:0] a_val,
    input  logic              a_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [DATA_W-1:0] b_val,
    input  logic              b_last,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              order_err
);

    state_t            state;
    state_t            state_n;
    mode_t             mode_q;
    logic              clear;
    logic              issue;
    logic              flush_cnt;
    logic [IDX_W-1:0]  a_prev;
    logic [IDX_W-1:0]  b_prev;
    logic              a_seen;
    logic              b_seen;
    logic              a_fire;
    logic              b_fire;
    logic              a_bad;
    logic              b_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        a_ready = 1'b0;
        b_ready = 1'b0;
        clear   = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (a_valid && b_valid) begin
                    if (a_idx == b_idx) begin
                        a_ready = 1'b1;
                        b_ready = 1'b1;
                        issue   = 1'b1;
                    end else if (a_idx < b_idx) begin
                        a_ready = 1'b1;
                    end else begin
                        b_ready = 1'b1;
                    end
                    if (a_ready && a_last && b_ready && b_last) begin
                        state_n = FLUSH;
                    end else if (a_ready && a_last) begin
                        state_n = DRAIN_B;
                    end else if (b_ready && b_last) begin
                        state_n = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                a_ready = a_valid;
                if (a_valid && a_last) begin
                    state_n = FLUSH;
                end
            end
            DRAIN_B: begin
                b_ready = b_valid;
                if (b_valid && b_last) begin
                    state_n = FLUSH;
                end
            end
            // Two cycles cover the product and accumulate stages.
            FLUSH: begin
                if (flush_cnt) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;
    assign a_bad  = a_fire && a_seen && (a_idx <= a_prev);
    assign b_bad  = b_fire && b_seen && (b_idx <= b_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_DOT;
            a_prev    <= '0;
            b_prev    <= '0;
            a_seen    <= 1'b0;
            b_seen    <= 1'b0;
            order_err <= 1'b0;
        end else if (clear) begin
            mode_q    <= mode_t'(mode);
            a_prev    <= '0;
            b_prev    <= '0;
            a_seen    <= 1'b0;
            b_seen    <= 1'b0;
            order_err <= 1'b0;
        end else begin
            if (a_fire) begin
                a_prev <= a_idx;
                a_seen <= 1'b1;
            end
            if (b_fire) begin
                b_prev <= b_idx;
                b_seen <= 1'b1;
            end
            if (a_bad || b_bad) begin
                order_err <= 1'b1;
            end
        end
    end

    sparse_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .en       (issue),
        .mode     (mode_q),
        .a_val    (a_val),
        .b_val    (b_val),
        .acc      (result),
        .overflow (overflow)
    );

    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

endmodule

// File: tb/tb_sparse_dot_engine.sv
// Randomized + directed scoreboard bench for sparse_dot_engine.
module tb_sparse_dot_engine;

    typedef struct {
        int idx;
        int val;
    } elem_t;

    typedef struct {
        longint result;
        bit     ov;
        bit     oe;
    } exp_t;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [15:0] a_idx = '0;
    logic [15:0] a_val = '0;
    logic        a_last = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_idx = '0;
    logic [15:0] b_val = '0;
    logic        b_last = 1'b0;
    logic        busy;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;
    logic        order_err;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_acc = -100;
    int   done_cnt = 0;
    bit   job_active = 0;
    bit   busy_drop = 0;
    bit   rv_prev = 0;
    exp_t sb[$];

    sparse_dot_engine #(
        .IDX_W  (16),
        .DATA_W (16),
        .ACC_W  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_idx     (a_idx),
        .a_val     (a_val),
        .a_last    (a_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_idx     (b_idx),
        .b_val     (b_val),
        .b_last    (b_last),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .overflow  (overflow),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic elem_t el(input int i, input int v);
        elem_t e;
        e.idx = i;
        e.val = v;
        return e;
    endfunction

    function automatic exp_t mk_exp(input longint r, input bit ov, input bit oe);
        exp_t e;
        e.result = r;
        e.ov     = ov;
        e.oe     = oe;
        return e;
    endfunction

    // Set intersection on index, accumulated in ascending index order with
    // clamping after every addition.
    function automatic exp_t model(input bit m, input elem_t a[$], input elem_t b[$]);
        exp_t   e;
        int     bmap[int];
        longint p;
        e.result = 0;
        e.ov     = 0;
        e.oe     = 0;
        foreach (b[i]) bmap[b[i].idx] = b[i].val;
        foreach (a[i]) begin
            if (bmap.exists(a[i].idx)) begin
                p = m ? 64'sd1 : longint'(a[i].val) * longint'(bmap[a[i].idx]);
                e.result += p;
                if (e.result > MAXV) begin
                    e.result = MAXV;
                    e.ov     = 1;
                end else if (e.result < MINV) begin
                    e.result = MINV;
                    e.ov     = 1;
                end
            end
        end
        for (int i = 1; i < a.size(); i++) if (a[i].idx <= a[i-1].idx) e.oe = 1;
        for (int i = 1; i < b.size(); i++) if (b[i].idx <= b[i-1].idx) e.oe = 1;
        return e;
    endfunction

    // Scoreboard monitor: compares on the result handshake, checks the
    // FLUSH latency on res_valid rising and busy continuity during a job.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (job_active && !busy) busy_drop = 1;
            if (res_valid && !rv_prev && job_active)
                chk("done_latency", longint'(cyc - last_acc), 3);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    report_fail("scoreboard_empty");
                end else begin
                    e = sb.pop_front();
                    chk("result", longint'($signed(result)), e.result);
                    chk("overflow", longint'(overflow), longint'(e.ov));
                    chk("order_err", longint'(order_err), longint'(e.oe));
                    chk("busy_held", longint'(busy_drop), 0);
                end
                job_active = 0;
                done_cnt++;
            end
        end
        rv_prev = res_valid;
    end

    task automatic drive_a(input elem_t v[$]);
        int i = 0;
        int guard = 0;
        bit fired;
        while (i < v.size() && guard < 1000) begin
            if ($urandom_range(0, 3) != 0) begin
                a_valid = 1;
                a_idx   = 16'(v[i].idx);
                a_val   = 16'(v[i].val);
                a_last  = (i == v.size() - 1);
            end else begin
                a_valid = 0;
                a_idx   = 16'($urandom);
                a_last  = 1'($urandom);
            end
            @(negedge clk);
            fired = a_valid && a_ready;
            if (fired && a_last) last_acc = cyc;
            @(posedge clk);
            #1;
            if (fired) i++;
            guard++;
        end
        a_valid = 0;
        a_last  = 0;
        if (i < v.size()) report_fail("a_stream_stall");
    endtask

    task automatic drive_b(input elem_t v[$]);
        int i = 0;
        int guard = 0;
        bit fired;
        while (i < v.size() && guard < 1000) begin
            if ($urandom_range(0, 3) != 0) begin
                b_valid = 1;
                b_idx   = 16'(v[i].idx);
                b_val   = 16'(v[i].val);
                b_last  = (i == v.size() - 1);
            end else begin
                b_valid = 0;
                b_idx   = 16'($urandom);
                b_last  = 1'($urandom);
            end
            @(negedge clk);
            fired = b_valid && b_ready;
            if (fired && b_last) last_acc = cyc;
            @(posedge clk);
            #1;
            if (fired) i++;
            guard++;
        end
        b_valid = 0;
        b_last  = 0;
        if (i < v.size()) report_fail("b_stream_stall");
    endtask

    // Called at posedge+1. With hold set, the result is back-pressured for
    // ten cycles with random start pulses, then consumed alongside a start.
    task automatic run_job(input bit m, input elem_t a[$], input elem_t b[$],
                           input exp_t e, input bit hold);
        int target;
        int k;
        sb.push_back(e);
        target    = done_cnt + 1;
        busy_drop = 0;
        last_acc  = -100;
        res_ready = !hold;
        start     = 1;
        mode      = m;
        @(posedge clk);
        #1;
        start      = 0;
        mode       = 1'($urandom);
        job_active = 1;
        fork
            drive_a(a);
            drive_b(b);
        join
        if (hold) begin
            k = 0;
            while (!res_valid && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (!res_valid) report_fail("bp_wait_done");
            for (int c = 0; c < 10; c++) begin
                start = 1'($urandom);
                @(negedge clk);
                chk("bp_res_valid", longint'(res_valid), 1);
                chk("bp_result", longint'($signed(result)), e.result);
                @(posedge clk);
                #1;
            end
            res_ready = 1;
            start     = 1;
            @(posedge clk);
            #1;
            start = 0;
            @(negedge clk);
            chk("bp_res_valid_fall", longint'(res_valid), 0);
            chk("bp_start_ignored", longint'(busy), 0);
            @(posedge clk);
            #1;
        end
        k = 0;
        while (done_cnt < target && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt < target) begin
            report_fail("job_timeout");
            sb.delete();
            job_active = 0;
            reset = 1;
            @(posedge clk);
            #1;
            reset = 0;
        end
        res_ready = 1;
    endtask

    task automatic gen_vec(output elem_t v[$]);
        v = {};
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0)
                v.push_back(el(i, int'($urandom_range(0, 65535)) - 32768));
        end
        if (v.size() == 0) v.push_back(el(int'($urandom_range(0, 15)), 0));
    endtask

    initial begin
        elem_t a[$];
        elem_t b[$];
        bit    m;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_a_ready", longint'(a_ready), 0);
        chk("rst_b_ready", longint'(b_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_order_err", longint'(order_err), 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;

        // Basic dot product and count mode
        a = {};
        b = {};
        a.push_back(el(1, 2));
        a.push_back(el(3, 4));
        a.push_back(el(7, -1));
        b.push_back(el(3, 5));
        b.push_back(el(7, 6));
        b.push_back(el(9, 2));
        run_job(0, a, b, mk_exp(14, 0, 0), 0);
        run_job(1, a, b, mk_exp(2, 0, 0), 0);

        // Backpressure on the same vectors
        run_job(0, a, b, mk_exp(14, 0, 0), 1);

        // Drain path
        a = {};
        b = {};
        a.push_back(el(2, 3));
        b.push_back(el(0, 1));
        b.push_back(el(2, 4));
        b.push_back(el(5, 9));
        b.push_back(el(8, 9));
        run_job(0, a, b, mk_exp(12, 0, 0), 0);

        // Saturation
        a = {};
        for (int i = 0; i < 3; i++) a.push_back(el(i, 32767));
        run_job(0, a, a, mk_exp(2147483647, 1, 0), 0);

        // Order error: duplicate index in A is drained, result unaffected
        a = {};
        b = {};
        a.push_back(el(4, 1));
        a.push_back(el(4, 1));
        b.push_back(el(4, 2));
        run_job(0, a, b, mk_exp(2, 0, 1), 0);

        // Reset mid-RUN after a few matched products
        start = 1;
        mode  = 0;
        @(posedge clk);
        #1;
        start = 0;
        for (int k = 1; k <= 3; k++) begin
            a_valid = 1;
            b_valid = 1;
            a_idx   = 16'(k);
            b_idx   = 16'(k);
            a_val   = 16'd100;
            b_val   = 16'd3;
            a_last  = 0;
            b_last  = 0;
            @(posedge clk);
            #1;
        end
        reset = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_a_ready", longint'(a_ready), 0);
        chk("abort_b_ready", longint'(b_ready), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_res_valid", longint'(res_valid), 0);
        chk("abort_result", longint'(result), 0);
        chk("abort_overflow", longint'(overflow), 0);
        chk("abort_order_err", longint'(order_err), 0);
        @(posedge clk);
        #1;
        reset   = 0;
        a_valid = 0;
        b_valid = 0;
        a = {};
        b = {};
        a.push_back(el(1, 2));
        a.push_back(el(3, 4));
        a.push_back(el(7, -1));
        b.push_back(el(3, 5));
        b.push_back(el(7, 6));
        b.push_back(el(9, 2));
        run_job(0, a, b, mk_exp(14, 0, 0), 0);

        // Randomized jobs against the reference model
        for (int j = 0; j < 40; j++) begin
            gen_vec(a);
            gen_vec(b);
            m = ($urandom_range(0, 3) == 0);
            run_job(m, a, b, model(m, a, b), 0);
        end

        repeat (2) @(posedge clk);
        if (sb.size() != 0) report_fail("scoreboard_leftover");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
